harq_llr_receiver: RTL and testbench
====================================

Name: harq_llr_receiver

Overview:
- HARQ-side receiver for the LLR stream produced by the SENDHARQ sender FSM.
- Accepts bursts of 96-bit words (16 lanes × 6-bit LLR), one burst per code block (CB).
- Writes each word into the HARQ buffer SRAM with a per-lane write mask, at address {user, cb, word}.
- Reports per-CB completion with the LLR count, and flags protocol errors.

Parameters:
- USER_W, 3, user-index bits used for addressing (8 users).
- CB_W, 4, CB-index bits used for addressing (16 CBs per user).
- WORD_W, 11, word-offset bits per CB (max 2048 words).
- LANES, 16, LLRs per word.
- LLR_W, 6, bits per LLR.

Ports:
- i_core_clk  in  1  core clock.
- i_rx_rst  in  1  asynchronous, active-high reset.
- i_rdm_slot_start  in  1  slot-start pulse; aborts any open burst.
- i_harq_data  in  LANES*LLR_W (96)  LLR word; lane k occupies bits [6k+5:6k].
- i_harq_valid  in  1  word valid; held high for the whole burst.
- i_harq_amount  in  4  index of the last valid lane in this word (15 = full word).
- i_harq_user_index  in  4  user of the burst.
- i_harq_cb_index  in  8  CB of the burst.
- o_harq_wr_en  out  1  SRAM write enable.
- o_harq_wr_addr  out  USER_W+CB_W+WORD_W (18)  {user[2:0], cb[3:0], word}.
- o_harq_wr_data  out  96  registered copy of i_harq_data.
- o_harq_wr_mask  out  LANES  lane k enabled iff k <= amount.
- o_busy  out  1  high in RECV.
- o_cb_done  out  1  one-cycle pulse at burst close.
- o_cb_done_user  out  4  user of the closed burst.
- o_cb_done_cb  out  8  CB of the closed burst.
- o_cb_done_llr_cnt  out  16  total LLRs received in the closed burst.
- o_err_overflow  out  1  sticky; word counter exceeded 2^WORD_W-1.
- o_err_hdr_change  out  1  sticky; user or CB changed while valid stayed high.

Behaviour:
- Reset (async, i_rx_rst=1): state IDLE; every output, counter and latched header = 0.
- States: IDLE, RECV, DONE.
- IDLE:
  - On valid=1: latch user/cb, word_cnt=0, llr_cnt=0, go RECV.
  - That first word is written (same handling as RECV).
- RECV:
  - Each edge with valid=1 registers a write: o_harq_wr_en=1 in the following cycle, addr {user,cb,word_cnt}, then word_cnt+1.
  - llr_cnt += amount+1, 16-bit, wrapping.
  - Write latency: exactly 1 cycle from input sample to wr_en/addr/data/mask.
- Burst close: when valid=0 is sampled in RECV:
  - go DONE.
  - o_cb_done=1 for exactly the one cycle immediately after the last wr_en cycle, with the latched user/cb and the final llr_cnt.
  - DONE -> IDLE unconditionally.
  - valid=1 sampled in DONE is treated as a new burst start, as in IDLE.
- Overflow:
  - A valid word arriving when word_cnt = 2^WORD_W-1 is still written.
  - After that, word_cnt holds and further words in the burst are dropped (wr_en=0) and set o_err_overflow.
- Header change: valid=1 in RECV with user or cb differing from the latched values:
  - set o_err_hdr_change;
  - the current burst closes (o_cb_done pulse with its counts);
  - the new word starts a fresh burst, written in the same cycle as the done pulse.
- Slot start: i_rdm_slot_start=1 has priority over all other inputs.
  - State -> IDLE; counters cleared; sticky errors cleared.
  - No o_cb_done pulse; any word sampled that cycle is dropped.
- Out-of-range user: user_index >= 8 or cb_index >= 16 → address uses the low bits; o_cb_done_user/cb report the full values.
- o_harq_wr_data/o_harq_wr_mask hold their last value when wr_en=0.

Decomposition:
- Shared package (harq_pkg):
  - LANES, LLR_W, USER_W, CB_W, WORD_W;
  - state encoding (one-hot, 3 bits);
  - address-pack function {user, cb, word}.
- One sub-module: harq_lane_mask, a combinational amount→16-bit thermometer mask, reused by the sender-side bench checker.

Test Plan:
- Single burst, user 2, cb 5, 3 words with amounts 15,15,7 → wr_en 3 cycles at addr {2,5,0..2}; last mask 0x00FF; o_cb_done one cycle later with llr_cnt=40.
- Two bursts user 0 cb 0 then user 0 cb 1, valid gap of 3 cycles → two done pulses with cb 0 and 1; second burst addresses restart at word 0.
- Header change: user 1 cb 3 for 2 words, then user 1 cb 4 with valid held high → o_err_hdr_change=1; done(cb 3, llr_cnt=32) in the same cycle as the first write to {1,4,0}.
- WORD_W=2, 6-word burst → 4 writes (words 0..3), o_err_overflow=1, done llr_cnt=96.
- i_rdm_slot_start during word 2 of a burst → no done pulse; o_busy=0 next cycle; errors cleared; next burst writes from word 0.
- i_rx_rst asserted mid-burst, asynchronously between edges → all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/harq_llr_receiver_pkg.sv
// Shared constants, FSM encoding and SRAM address packing for the HARQ LLR receive path.
package harq_pkg;

   localparam int LANES  = 16;
   localparam int LLR_W  = 6;
   localparam int USER_W = 3;
   localparam int CB_W   = 4;
   localparam int WORD_W = 11;
   localparam int DATA_W = LANES * LLR_W;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_RECV = 3'b010,
      ST_DONE = 3'b100
   } state_e;

   // word_w is passed explicitly so instances with a narrower word field share the helper
   function automatic logic [31:0] pack_addr(input logic [USER_W-1:0] user,
                                             input logic [CB_W-1:0]   cb,
                                             input logic [31:0]       word,
                                             input int unsigned       word_w);
      return (32'(user) << (CB_W + word_w)) | (32'(cb) << word_w) | word;
   endfunction

endpackage

// File: rtl/harq_llr_receiver_if.sv
// LLR burst stream from the SENDHARQ sender into the HARQ receiver.
interface harq_llr_receiver_if;
   import harq_pkg::*;

   logic [DATA_W-1:0] harq_data;
   logic              harq_valid;
   logic [3:0]        harq_amount;
   logic [3:0]        harq_user_index;
   logic [7:0]        harq_cb_index;

   modport master (
      output harq_data, harq_valid, harq_amount, harq_user_index, harq_cb_index
   );

   modport slave (
      input harq_data, harq_valid, harq_amount, harq_user_index, harq_cb_index
   );
endinterface

// File: rtl/harq_llr_receiver_lane_mask.sv
// Thermometer lane mask: lane k is enabled when k <= amount (index of the last valid lane).
module harq_lane_mask
   import harq_pkg::*;
(
   input  logic [3:0]       amount,
   output logic [LANES-1:0] mask
);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign mask[gi] = (4'(gi) <= amount);
      end
   endgenerate

endmodule

// File: rtl/harq_llr_receiver.sv
// Receives per-CB LLR bursts, writes them to the HARQ buffer and reports burst completion/errors.
module harq_llr_receiver
   import harq_pkg::*;
#(
   parameter int WORD_W = harq_pkg::WORD_W
) (
   input  logic                            i_core_clk,
   input  logic                            i_rx_rst,
   input  logic                            i_rdm_slot_start,
   harq_llr_receiver_if.slave              harq,
   output logic                            o_harq_wr_en,
   output logic [USER_W+CB_W+WORD_W-1:0]   o_harq_wr_addr,
   output logic [DATA_W-1:0]               o_harq_wr_data,
   output logic [LANES-1:0]                o_harq_wr_mask,
   output logic                            o_busy,
   output logic                            o_cb_done,
   output logic [3:0]                      o_cb_done_user,
   output logic [7:0]                      o_cb_done_cb,
   output logic [15:0]                     o_cb_done_llr_cnt,
   output logic                            o_err_overflow,
   output logic                            o_err_hdr_change
);

   localparam int ADDR_W = USER_W + CB_W + WORD_W;
   localparam logic [WORD_W-1:0] WORD_MAX = '1;

   state_e              state_reg, state_next;
   logic [3:0]          user_reg, user_next;
   logic [7:0]          cb_reg, cb_next;
   logic [WORD_W-1:0]   word_cnt_reg, word_cnt_next;
   logic                full_reg, full_next;
   logic [15:0]         llr_cnt_reg, llr_cnt_next;

   logic                wr_en_next;
   logic [ADDR_W-1:0]   wr_addr_next;
   logic [DATA_W-1:0]   wr_data_next;
   logic [LANES-1:0]    wr_mask_next;
   logic                done_next;
   logic [3:0]          done_user_next;
   logic [7:0]          done_cb_next;
   logic [15:0]         done_cnt_next;
   logic                err_ovf_next;
   logic                err_hdr_next;

   logic                start_burst;
   logic                close_burst;
   logic                write_word;
   logic                hdr_diff;
   logic [15:0]         llr_inc;
   logic [LANES-1:0]    lane_mask;

   harq_lane_mask u_lane_mask (
      .amount (harq.harq_amount),
      .mask   (lane_mask)
   );

   assign llr_inc  = 16'(harq.harq_amount) + 16'd1;
   assign hdr_diff = (harq.harq_user_index != user_reg) || (harq.harq_cb_index != cb_reg);
   assign o_busy   = (state_reg == ST_RECV);

   always_comb begin
      state_next     = state_reg;
      user_next      = user_reg;
      cb_next        = cb_reg;
      word_cnt_next  = word_cnt_reg;
      full_next      = full_reg;
      llr_cnt_next   = llr_cnt_reg;
      wr_en_next     = 1'b0;
      wr_addr_next   = o_harq_wr_addr;
      wr_data_next   = o_harq_wr_data;
      wr_mask_next   = o_harq_wr_mask;
      done_next      = 1'b0;
      done_user_next = o_cb_done_user;
      done_cb_next   = o_cb_done_cb;
      done_cnt_next  = o_cb_done_llr_cnt;
      err_ovf_next   = o_err_overflow;
      err_hdr_next   = o_err_hdr_change;
      start_burst    = 1'b0;
      close_burst    = 1'b0;
      write_word     = 1'b0;

      if (i_rdm_slot_start) begin
         state_next    = ST_IDLE;
         user_next     = '0;
         cb_next       = '0;
         word_cnt_next = '0;
         full_next     = 1'b0;
         llr_cnt_next  = '0;
         err_ovf_next  = 1'b0;
         err_hdr_next  = 1'b0;
      end else begin
         case (state_reg)
            ST_RECV: begin
               if (!harq.harq_valid) begin
                  close_burst = 1'b1;
                  state_next  = ST_DONE;
               end else if (hdr_diff) begin
                  close_burst  = 1'b1;
                  err_hdr_next = 1'b1;
                  start_burst  = 1'b1;
               end else begin
                  // once the last address is used, words are only counted, not written
                  llr_cnt_next = llr_cnt_reg + llr_inc;
                  if (full_reg) begin
                     err_ovf_next = 1'b1;
                  end else begin
                     write_word = 1'b1;
                  end
               end
            end
            default: begin
               state_next = ST_IDLE;
               if (harq.harq_valid) begin
                  start_burst = 1'b1;
               end
            end
         endcase
      end

      if (close_burst) begin
         done_next      = 1'b1;
         done_user_next = user_reg;
         done_cb_next   = cb_reg;
         done_cnt_next  = llr_cnt_reg;
      end

      if (start_burst) begin
         state_next    = ST_RECV;
         user_next     = harq.harq_user_index;
         cb_next       = harq.harq_cb_index;
         word_cnt_next = '0;
         full_next     = 1'b0;
         llr_cnt_next  = llr_inc;
         write_word    = 1'b1;
      end

      if (write_word) begin
         wr_en_next   = 1'b1;
         wr_addr_next = ADDR_W'(pack_addr(user_next[USER_W-1:0], cb_next[CB_W-1:0],
                                          32'(word_cnt_next), WORD_W));
         wr_data_next = harq.harq_data;
         wr_mask_next = lane_mask;
         if (word_cnt_next == WORD_MAX) begin
            full_next = 1'b1;
         end else begin
            word_cnt_next = word_cnt_next + 1'b1;
         end
      end
   end

   always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
      if (i_rx_rst) begin
         state_reg         <= ST_IDLE;
         user_reg          <= '0;
         cb_reg            <= '0;
         word_cnt_reg      <= '0;
         full_reg          <= 1'b0;
         llr_cnt_reg       <= '0;
         o_harq_wr_en      <= 1'b0;
         o_harq_wr_addr    <= '0;
         o_harq_wr_data    <= '0;
         o_harq_wr_mask    <= '0;
         o_cb_done         <= 1'b0;
         o_cb_done_user    <= '0;
         o_cb_done_cb      <= '0;
         o_cb_done_llr_cnt <= '0;
         o_err_overflow    <= 1'b0;
         o_err_hdr_change  <= 1'b0;
      end else begin
         state_reg         <= state_next;
         user_reg          <= user_next;
         cb_reg            <= cb_next;
         word_cnt_reg      <= word_cnt_next;
         full_reg          <= full_next;
         llr_cnt_reg       <= llr_cnt_next;
         o_harq_wr_en      <= wr_en_next;
         o_harq_wr_addr    <= wr_addr_next;
         o_harq_wr_data    <= wr_data_next;
         o_harq_wr_mask    <= wr_mask_next;
         o_cb_done         <= done_next;
         o_cb_done_user    <= done_user_next;
         o_cb_done_cb      <= done_cb_next;
         o_cb_done_llr_cnt <= done_cnt_next;
         o_err_overflow    <= err_ovf_next;
         o_err_hdr_change  <= err_hdr_next;
      end
   end

endmodule

// File: tb/tb_harq_llr_receiver.sv
// Two receivers (11-bit and 2-bit word field) fed one stream, each checked against a burst-level model.
module tb_harq_llr_receiver;
   import harq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic slot;
   int   total = 0;
   int   bad   = 0;
   logic out_nz [2];

   harq_llr_receiver_if bus ();

   always #5 clk = ~clk;

   task automatic check_value(input int inst, input string tag,
                              input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL inst%0d %s: got=%0h expected=%0h", inst, tag, got, exp);
      end
   endtask

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         localparam int WW = (gi == 0) ? 11 : 2;
         localparam int AW = USER_W + CB_W + WW;

         logic          wr_en, busy, done, eo, eh;
         logic [AW-1:0] addr;
         logic [95:0]   data;
         logic [15:0]   mask;
         logic [3:0]    du;
         logic [7:0]    dc;
         logic [15:0]   dcnt;

         harq_llr_receiver #(.WORD_W(WW)) u_dut (
            .i_core_clk        (clk),
            .i_rx_rst          (rst),
            .i_rdm_slot_start  (slot),
            .harq              (bus),
            .o_harq_wr_en      (wr_en),
            .o_harq_wr_addr    (addr),
            .o_harq_wr_data    (data),
            .o_harq_wr_mask    (mask),
            .o_busy            (busy),
            .o_cb_done         (done),
            .o_cb_done_user    (du),
            .o_cb_done_cb      (dc),
            .o_cb_done_llr_cnt (dcnt),
            .o_err_overflow    (eo),
            .o_err_hdr_change  (eh)
         );

         assign out_nz[gi] = |{wr_en, busy, done, eo, eh, addr, data, mask, du, dc, dcnt};

         // burst-level reference: one open burst, a word count and an LLR total
         bit          m_busy, m_eo, m_eh;
         int          m_user, m_cb, m_words, m_llr;
         bit          x_wr, x_done;
         int          x_addr, x_du, x_dc, x_cnt;
         logic [95:0] x_data;
         logic [15:0] x_mask;

         always @(posedge clk) begin
            x_wr   = 1'b0;
            x_done = 1'b0;
            if (rst) begin
               m_busy = 1'b0;
               m_eo   = 1'b0;
               m_eh   = 1'b0;
               x_data = '0;
               x_mask = '0;
            end else if (slot) begin
               m_busy = 1'b0;
               m_eo   = 1'b0;
               m_eh   = 1'b0;
            end else begin
               if (m_busy && (!bus.harq_valid ||
                              int'(bus.harq_user_index) != m_user ||
                              int'(bus.harq_cb_index) != m_cb)) begin
                  x_done = 1'b1;
                  x_du   = m_user;
                  x_dc   = m_cb;
                  x_cnt  = m_llr % 65536;
                  m_busy = 1'b0;
                  if (bus.harq_valid) m_eh = 1'b1;
               end
               if (bus.harq_valid) begin
                  if (!m_busy) begin
                     m_busy  = 1'b1;
                     m_user  = int'(bus.harq_user_index);
                     m_cb    = int'(bus.harq_cb_index);
                     m_words = 0;
                     m_llr   = 0;
                  end
                  m_llr += int'(bus.harq_amount) + 1;
                  if (m_words < (1 << WW)) begin
                     x_wr   = 1'b1;
                     x_addr = ((m_user % 8) << (CB_W + WW)) | ((m_cb % 16) << WW) | m_words;
                     x_data = bus.harq_data;
                     x_mask = 16'((1 << (int'(bus.harq_amount) + 1)) - 1);
                     m_words++;
                  end else begin
                     m_eo = 1'b1;
                  end
               end
            end
            #1;
            check_value(gi, "wr_en",   128'(wr_en), 128'(x_wr));
            check_value(gi, "busy",    128'(busy),  128'(m_busy));
            check_value(gi, "cb_done", 128'(done),  128'(x_done));
            check_value(gi, "err_ovf", 128'(eo),    128'(m_eo));
            check_value(gi, "err_hdr", 128'(eh),    128'(m_eh));
            check_value(gi, "wr_data", 128'(data),  128'(x_data));
            check_value(gi, "wr_mask", 128'(mask),  128'(x_mask));
            if (x_wr) check_value(gi, "wr_addr", 128'(addr), 128'(unsigned'(x_addr)));
            if (x_done) begin
               check_value(gi, "done_user", 128'(du),   128'(unsigned'(x_du)));
               check_value(gi, "done_cb",   128'(dc),   128'(unsigned'(x_dc)));
               check_value(gi, "done_cnt",  128'(dcnt), 128'(unsigned'(x_cnt)));
               if (gi == 0) $display("burst closed: user=%0d cb=%0d llr_cnt=%0d", x_du, x_dc, x_cnt);
            end
         end
      end
   endgenerate

   task automatic send(input logic v, input int u, input int c, input int a, input logic s);
      @(negedge clk);
      bus.harq_valid      = v;
      bus.harq_user_index = 4'(u);
      bus.harq_cb_index   = 8'(c);
      bus.harq_amount     = 4'(a);
      bus.harq_data       = {$urandom(), $urandom(), $urandom()};
      slot                = s;
   endtask

   task automatic idle(input int n);
      repeat (n) send(1'b0, 0, 0, 0, 1'b0);
   endtask

   initial begin
      int n, gap, u, c;
      rst                 = 1'b1;
      slot                = 1'b0;
      bus.harq_valid      = 1'b0;
      bus.harq_user_index = '0;
      bus.harq_cb_index   = '0;
      bus.harq_amount     = '0;
      bus.harq_data       = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // single burst: expect llr_cnt 40, last mask 0x00FF
      send(1, 2, 5, 15, 0); send(1, 2, 5, 15, 0); send(1, 2, 5, 7, 0);
      idle(3);
      // back-to-back CBs with a gap
      send(1, 0, 0, 15, 0); send(1, 0, 0, 3, 0);
      idle(3);
      send(1, 0, 1, 15, 0); send(1, 0, 1, 0, 0);
      idle(3);
      // header change with valid held
      send(1, 1, 3, 15, 0); send(1, 1, 3, 15, 0);
      send(1, 1, 4, 15, 0); send(1, 1, 4, 9, 0);
      idle(3);
      // six words: the 2-bit instance overflows after four
      repeat (6) send(1, 3, 7, 15, 0);
      idle(3);
      // slot start during word 2, then a fresh burst
      send(1, 4, 2, 15, 0); send(1, 4, 2, 15, 0); send(1, 4, 2, 15, 1);
      idle(2);
      send(1, 4, 2, 5, 0); send(1, 4, 2, 6, 0);
      idle(3);
      // out-of-range header
      send(1, 12, 200, 15, 0); send(1, 12, 200, 1, 0);
      idle(3);

      for (int b = 0; b < 40; b++) begin
         n   = $urandom_range(1, 7);
         u   = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
         c   = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15);
         gap = $urandom_range(0, 3);
         for (int w = 0; w < n; w++)
            send(1, u, c, $urandom_range(0, 15), ($urandom_range(0, 40) == 0));
         idle(gap);
      end
      idle(3);

      // asynchronous reset between edges, mid-burst
      send(1, 5, 9, 15, 0); send(1, 5, 9, 15, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) check_value(i, "async_rst_outputs", 128'(out_nz[i]), 128'(0));
      @(negedge clk);
      bus.harq_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      send(1, 6, 1, 3, 0); send(1, 6, 1, 15, 0);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
